fm_backward_search: RTL and testbench
=====================================

FM_BACKWARD_SEARCH -- requirements
Module: fm_backward_search

Interface
REQ-001 Parameter SYM_W, default 2, symbol width in bits (alphabet size 2^SYM_W).
REQ-002 Parameter IDX_W, default 32, width of the SA interval bounds, C and Occ data.
REQ-003 Parameter LEN_W, default 8, width of the read length and read-symbol address.
REQ-004 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start_i  in  1  start request, sampled only in IDLE.
REQ-008 read_len_i  in  LEN_W  number of read symbols, sampled with start_i.
REQ-009 bwt_len_i  in  IDX_W  BWT length N, sampled with start_i.
REQ-010 busy_o  out  1  high in every state except IDLE.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 found_o, k_o, l_o  out  1, IDX_W, IDX_W  result flag and final interval, held until the next accepted start.
REQ-013 ce_read_o, addr_read_o, read_sym_i  out/out/in  1, LEN_W, SYM_W  read-symbol memory port; data valid one cycle after ce.
REQ-014 ce_c_o, addr_c_o, c_data_i  out/out/in  1, SYM_W, IDX_W  C table port; data valid one cycle after ce.
REQ-015 ce_occ_o, occ_sym_o, addr1_occ_o, addr2_occ_o, data_1_i, data_2_i  out/out/out/out/in/in  1, SYM_W, IDX_W, IDX_W, IDX_W, IDX_W  dual-address Occ port; data valid one cycle after ce.

Function
REQ-016 The FSM states SHALL be IDLE, SYM, ROM, UPD, DONE.
REQ-017 IDLE -> SYM on start_i with read_len_i != 0; IDLE -> DONE on start_i with read_len_i == 0.
REQ-018 On the accepted start: k <= 0, l <= bwt_len_i - 1, i <= read_len_i - 1, found <= 1.
REQ-019 SYM: ce_read_o = 1, addr_read_o = i; next ROM.
REQ-020 ROM: a = read_sym_i. Drive ce_c_o = 1, addr_c_o = a, ce_occ_o = 1, occ_sym_o = a, addr1_occ_o = k - 1, addr2_occ_o = l. Register a. Next UPD.
REQ-021 UPD: k' = c_data_i + occ1 + 1 and l' = c_data_i + data_2_i, with occ1 = 0 when k == 0, else data_1_i. All sums are modulo 2^IDX_W.
REQ-022 UPD exit: if k' > l' (unsigned), found <= 0 -> DONE; else if i == 0 -> DONE; else i <= i - 1 -> SYM.
REQ-023 DONE: done_o = 1 for exactly one cycle; k_o/l_o/found_o already reflect the final values; next IDLE.
REQ-024 Latency: done_o SHALL assert 3*n + 1 cycles after the start cycle for a full-length search of n symbols. It SHALL assert 3*m + 1 cycles after start when the mismatch is detected at step m.
REQ-025 start_i outside IDLE SHALL be ignored, and the in-flight search SHALL be unaffected.
REQ-026 All ce_* outputs SHALL be 0 in states where they are not listed above.
REQ-027 Address outputs SHALL be don't-care when their ce is 0.

Reset
REQ-028 rst SHALL force IDLE from any state, including mid-search, with no done_o pulse.
REQ-029 rst SHALL clear busy_o, done_o, found_o, k_o, l_o, all ce_* and all address outputs to 0.
REQ-030 The first start_i after rst deasserts SHALL be accepted if rst is low in that cycle.

Configuration
REQ-031 With macro FM_SEARCH_STEP_CNT_EN defined, the block SHALL add output steps_o (LEN_W). steps_o is cleared on start and reset and incremented in every UPD cycle, so it gives the number of symbols consumed.
REQ-032 Without FM_SEARCH_STEP_CNT_EN, steps_o and its counter SHALL not exist, and all other behaviour is identical.

Verification
REQ-033 Single symbol: read_len=1, bwt_len=8, c_data=2, data_2=3 -> k_o=3, l_o=5, found_o=1, done_o at cycle 4, data_1 ignored (k=0).
REQ-034 Early mismatch: read_len=4, c_data=2, data_2=0 -> found_o=0, done_o at cycle 4 (not 13), steps_o=1 if enabled.
REQ-035 Empty read: read_len=0, bwt_len=10 -> done_o at cycle 1, found_o=1, k_o=0, l_o=9, no ce_* asserted.
REQ-036 Multi-step: read_len=3 with a ROM model of a known FM-index. Checks: k_o/l_o match the golden model, done_o at cycle 10, addr_read_o sequence 2,1,0, addr1_occ_o = k-1 on steps 2 and 3.
REQ-037 Reset mid-search at cycle 5 of a read_len=5 search -> IDLE next cycle, all outputs 0, no done_o. A start two cycles later completes normally.
REQ-038 start_i held high throughout a search -> exactly one search. A new search starts only in the IDLE cycle following DONE.

Source files
------------

// File: rtl/fm_backward_search.sv
// rtl/fm_backward_search.sv - FM-index backward search engine over an external C/Occ/read-symbol memory set.
// Optional step counter output steps_o is built when FM_SEARCH_STEP_CNT_EN is defined.
module fm_backward_search #(
   parameter int SYM_W = 2,
   parameter int IDX_W = 32,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [LEN_W-1:0] read_len_i,
   input  logic [IDX_W-1:0] bwt_len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             found_o,
   output logic [IDX_W-1:0] k_o,
   output logic [IDX_W-1:0] l_o,
   output logic             ce_read_o,
   output logic [LEN_W-1:0] addr_read_o,
   input  logic [SYM_W-1:0] read_sym_i,
   output logic             ce_c_o,
   output logic [SYM_W-1:0] addr_c_o,
   input  logic [IDX_W-1:0] c_data_i,
   output logic             ce_occ_o,
   output logic [SYM_W-1:0] occ_sym_o,
   output logic [IDX_W-1:0] addr1_occ_o,
   output logic [IDX_W-1:0] addr2_occ_o,
   input  logic [IDX_W-1:0] data_1_i,
`ifdef FM_SEARCH_STEP_CNT_EN
   output logic [LEN_W-1:0] steps_o,
`endif
   input  logic [IDX_W-1:0] data_2_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SYM  = 3'd1;
   localparam logic [2:0] S_ROM  = 3'd2;
   localparam logic [2:0] S_UPD  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state;
   logic [IDX_W-1:0] k;
   logic [IDX_W-1:0] l;
   logic [LEN_W-1:0] i;
   logic             found;
   logic [IDX_W-1:0] occ1;
   logic [IDX_W-1:0] k_next;
   logic [IDX_W-1:0] l_next;

`ifdef FM_SEARCH_STEP_CNT_EN
   logic [LEN_W-1:0] steps;
   assign steps_o = steps;
`endif

   assign busy_o  = (state != S_IDLE);
   assign done_o  = (state == S_DONE);
   assign found_o = found;
   assign k_o     = k;
   assign l_o     = l;

   // Addresses are forced to zero whenever their strobe is low so reset leaves every output at 0.
   assign ce_read_o   = (state == S_SYM);
   assign addr_read_o = ce_read_o ? i : '0;

   assign ce_c_o      = (state == S_ROM);
   assign addr_c_o    = ce_c_o ? read_sym_i : '0;

   assign ce_occ_o    = (state == S_ROM);
   assign occ_sym_o   = ce_occ_o ? read_sym_i : '0;
   assign addr1_occ_o = ce_occ_o ? (k - IDX_W'(1)) : '0;
   assign addr2_occ_o = ce_occ_o ? l : '0;

   // Occ(a, -1) is zero by definition; the memory answer for address k-1 is meaningless when k == 0.
   assign occ1   = (k == '0) ? '0 : data_1_i;
   assign k_next = c_data_i + occ1 + IDX_W'(1);
   assign l_next = c_data_i + data_2_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         k     <= '0;
         l     <= '0;
         i     <= '0;
         found <= 1'b0;
`ifdef FM_SEARCH_STEP_CNT_EN
         steps <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  k     <= '0;
                  l     <= bwt_len_i - IDX_W'(1);
                  i     <= read_len_i - LEN_W'(1);
                  found <= 1'b1;
`ifdef FM_SEARCH_STEP_CNT_EN
                  steps <= '0;
`endif
                  state <= (read_len_i != '0) ? S_SYM : S_DONE;
               end
            end
            S_SYM: state <= S_ROM;
            S_ROM: state <= S_UPD;
            S_UPD: begin
               k <= k_next;
               l <= l_next;
`ifdef FM_SEARCH_STEP_CNT_EN
               steps <= steps + LEN_W'(1);
`endif
               if (k_next > l_next) begin
                  found <= 1'b0;
                  state <= S_DONE;
               end else if (i == '0) begin
                  state <= S_DONE;
               end else begin
                  i     <= i - LEN_W'(1);
                  state <= S_SYM;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fm_backward_search.sv
// tb/tb_fm_backward_search.sv - directed self-checking bench for fm_backward_search.
module tb_fm_backward_search;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [7:0]  read_len_i;
   logic [31:0] bwt_len_i;
   logic        busy_o, done_o, found_o;
   logic [31:0] k_o, l_o;
   logic        ce_read_o;
   logic [7:0]  addr_read_o;
   logic [1:0]  read_sym_i;
   logic        ce_c_o;
   logic [1:0]  addr_c_o;
   logic [31:0] c_data_i;
   logic        ce_occ_o;
   logic [1:0]  occ_sym_o;
   logic [31:0] addr1_occ_o, addr2_occ_o;
   logic [31:0] data_1_i, data_2_i;
`ifdef FM_SEARCH_STEP_CNT_EN
   logic [7:0]  steps_o;
`endif

   fm_backward_search dut (
      .clk(clk), .rst(rst), .start_i(start_i), .read_len_i(read_len_i), .bwt_len_i(bwt_len_i),
      .busy_o(busy_o), .done_o(done_o), .found_o(found_o), .k_o(k_o), .l_o(l_o),
      .ce_read_o(ce_read_o), .addr_read_o(addr_read_o), .read_sym_i(read_sym_i),
      .ce_c_o(ce_c_o), .addr_c_o(addr_c_o), .c_data_i(c_data_i),
      .ce_occ_o(ce_occ_o), .occ_sym_o(occ_sym_o), .addr1_occ_o(addr1_occ_o),
      .addr2_occ_o(addr2_occ_o), .data_1_i(data_1_i),
`ifdef FM_SEARCH_STEP_CNT_EN
      .steps_o(steps_o),
`endif
      .data_2_i(data_2_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model: mode 0 returns constants, mode 1 serves the FM-index of "ACACA$".
   int          mode = 0;
   logic [31:0] c_const = 0, d1_const = 0, d2_const = 0;
   logic [1:0]  read_mem [0:15];
   logic [31:0] c_tab [0:3];
   int          bwt [0:5];

   function automatic logic [31:0] occ(input logic [1:0] a, input logic [31:0] idx);
      int n = 0;
      if (idx > 32'd5) return 32'hdead;
      for (int j = 0; j <= int'(idx); j++)
         if (bwt[j] == int'(a)) n++;
      return n;
   endfunction

   always @(posedge clk) begin
      if (ce_read_o) read_sym_i <= read_mem[addr_read_o[3:0]];
      if (ce_c_o) c_data_i <= (mode == 1) ? c_tab[addr_c_o] : c_const;
      if (ce_occ_o) begin
         data_1_i <= (mode == 1) ? occ(occ_sym_o, addr1_occ_o) : d1_const;
         data_2_i <= (mode == 1) ? occ(occ_sym_o, addr2_occ_o) : d2_const;
      end
   end

   logic [31:0] aq[$];
   logic [31:0] oq[$];
   int ce_seen  = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      if (ce_read_o) aq.push_back(32'(addr_read_o));
      if (ce_occ_o) oq.push_back(addr1_occ_o);
      if (ce_read_o || ce_c_o || ce_occ_o) ce_seen++;
      if (done_o) done_cnt++;
   end

   task automatic clear_mon();
      aq.delete();
      oq.delete();
      ce_seen  = 0;
      done_cnt = 0;
   endtask

   // Starts a search in the current cycle; lat is the cycle (start cycle = 0) of done_o, -1 on timeout.
   task automatic run(input logic [7:0] len, input logic [31:0] blen, output int lat);
      int c = 1;
      start_i = 1'b1; read_len_i = len; bwt_len_i = blen;
      @(posedge clk); #1;
      start_i = 1'b0;
      while (!done_o && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      lat = done_o ? c : -1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"}, busy_o, 0);
      check_eq({tag, "_done"}, done_o, 0);
      check_eq({tag, "_found"}, found_o, 0);
      check_eq({tag, "_k"}, k_o, 0);
      check_eq({tag, "_l"}, l_o, 0);
      check_eq({tag, "_ce"}, {ce_read_o, ce_c_o, ce_occ_o}, 0);
      check_eq({tag, "_addr"}, {addr_read_o, addr_c_o, occ_sym_o, addr1_occ_o, addr2_occ_o}, 0);
   endtask

   initial begin
      int lat, first, second;
      start_i = 0; read_len_i = 0; bwt_len_i = 0; rst = 1;
      read_sym_i = 0; c_data_i = 0; data_1_i = 0; data_2_i = 0;
      for (int j = 0; j < 16; j++) read_mem[j] = 2'd0;
      read_mem[0] = 2'd0; read_mem[1] = 2'd1; read_mem[2] = 2'd0;
      c_tab[0] = 0; c_tab[1] = 3; c_tab[2] = 5; c_tab[3] = 5;
      bwt[0] = 0; bwt[1] = 1; bwt[2] = 1; bwt[3] = 4; bwt[4] = 0; bwt[5] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      check_idle_outputs("reset");

      // Single symbol, started in the first cycle after reset release.
      mode = 0; c_const = 2; d1_const = 7; d2_const = 3;
      clear_mon();
      run(8'd1, 32'd8, lat);
      check_eq("single_lat", lat, 4);
      check_eq("single_k", k_o, 3);
      check_eq("single_l", l_o, 5);
      check_eq("single_found", found_o, 1);
      @(posedge clk); #1;

      // Mismatch on the first step of a four-symbol read.
      c_const = 2; d2_const = 0;
      clear_mon();
      run(8'd4, 32'd16, lat);
      check_eq("mismatch_lat", lat, 4);
      check_eq("mismatch_found", found_o, 0);
`ifdef FM_SEARCH_STEP_CNT_EN
      check_eq("mismatch_steps", steps_o, 1);
`endif
      @(posedge clk); #1;

      // Empty read.
      clear_mon();
      run(8'd0, 32'd10, lat);
      check_eq("empty_lat", lat, 1);
      check_eq("empty_found", found_o, 1);
      check_eq("empty_k", k_o, 0);
      check_eq("empty_l", l_o, 9);
      check_eq("empty_ce", ce_seen, 0);
      @(posedge clk); #1;

      // Three-symbol search of "ACA" in "ACACA$": intervals [1,3] -> [4,5] -> [2,3].
      mode = 1;
      clear_mon();
      run(8'd3, 32'd6, lat);
      check_eq("multi_lat", lat, 10);
      check_eq("multi_k", k_o, 2);
      check_eq("multi_l", l_o, 3);
      check_eq("multi_found", found_o, 1);
      check_eq("multi_nread", aq.size(), 3);
      check_eq("multi_addr_read0", aq[0], 2);
      check_eq("multi_addr_read1", aq[1], 1);
      check_eq("multi_addr_read2", aq[2], 0);
      check_eq("multi_nocc", oq.size(), 3);
      check_eq("multi_addr1_step2", oq[1], 0);
      check_eq("multi_addr1_step3", oq[2], 3);
`ifdef FM_SEARCH_STEP_CNT_EN
      check_eq("multi_steps", steps_o, 3);
`endif
      @(posedge clk); #1;

      // Reset in cycle 5 of a five-symbol search, then a normal restart two cycles later.
      mode = 0; c_const = 0; d1_const = 0; d2_const = 5;
      clear_mon();
      start_i = 1; read_len_i = 8'd5; bwt_len_i = 32'd20;
      @(posedge clk); #1;
      start_i = 0;
      repeat (4) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check_idle_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      check_eq("midrst_no_done", done_cnt, 0);
      run(8'd5, 32'd20, lat);
      check_eq("restart_lat", lat, 16);
      check_eq("restart_k", k_o, 1);
      check_eq("restart_l", l_o, 5);
      check_eq("restart_found", found_o, 1);
      @(posedge clk); #1;

      // start_i held high: second search only begins in the IDLE cycle after DONE.
      c_const = 2; d1_const = 7; d2_const = 3;
      first = -1; second = -1;
      start_i = 1; read_len_i = 8'd1; bwt_len_i = 32'd8;
      @(posedge clk); #1;
      for (int c = 1; c <= 10; c++) begin
         if (done_o) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         @(posedge clk); #1;
      end
      start_i = 0;
      check_eq("held_first_done", first, 4);
      check_eq("held_second_done", second, 9);
      for (int c = 0; c < 20 && busy_o; c++) begin
         @(posedge clk); #1;
      end
      check_eq("held_idle", busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
